matrix_input_collector: RTL and testbench
=========================================

Name: matrix_input_collector

Overview:
- User-entry front end of the calculator's input mode; the input-side counterpart of the 7-segment display path.
- Synchronises and debounces the raw confirm/cancel buttons and samples the switch value on each confirmed press.
- Collects matrix dimensions m, n, then m*n element values, and streams accepted elements to matrix storage over a write port.
- Drives in_count (shown on the display), an error pulse for the error/countdown FSM, and a completion flag.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz)
MAX_DIM, 5, largest legal row/column count (min is 1)
MAX_VAL, 9, largest legal element value (min is 0)
ADDR_W, 5, width of wr_addr (must hold MAX_DIM*MAX_DIM-1)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
enable  in  1  high while the system is in input mode (sw_mode==000)
btn_confirm  in  1  raw, asynchronous, active-high confirm button
btn_cancel  in  1  raw, asynchronous, active-high cancel/undo button
sw_data  in  8  unsigned value to enter
in_count  out  8  number of accepted entries, dimensions included
wr_en  out  1  one-cycle element write strobe
wr_addr  out  ADDR_W  row-major element index
wr_data  out  8  element value
dim_m  out  3  accepted row count
dim_n  out  3  accepted column count
input_done  out  1  level; all m*n elements accepted
err_pulse  out  1  one-cycle pulse; entry rejected

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. All outputs and internal registers go to 0; state goes to S_IDLE.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debouncer: counter resets whenever the synchronised level equals the debounced level. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips.
- Press event: a debounced 0->1 edge gives a one-cycle press event. Releases generate nothing.
- Latency: an action is taken in the cycle after its press event, so outputs update on the following edge.
- Priority:
  - If confirm and cancel events occur in the same cycle, cancel wins and confirm is dropped.
  - enable low overrides both.
- S_IDLE: in_count=0, input_done=0.
  - enable high -> S_GET_M.
  - Button events are ignored.
- S_GET_M, confirm:
  - If 1 <= sw_data <= MAX_DIM: dim_m<=sw_data[2:0], in_count<=1 -> S_GET_N.
  - Otherwise err_pulse=1 and state is unchanged.
  - Cancel: no effect.
- S_GET_N, confirm:
  - If legal: dim_n<=sw_data[2:0], in_count<=2, target<=dim_m*dim_n (5-bit product), idx<=0 -> S_GET_ELEM.
  - Otherwise err_pulse.
  - Cancel: in_count<=0 -> S_GET_M.
- S_GET_ELEM, confirm:
  - If sw_data <= MAX_VAL: wr_en=1 for one cycle with wr_addr=idx and wr_data=sw_data; idx<=idx+1; in_count<=in_count+1.
  - If idx==target-1: -> S_DONE and input_done<=1.
  - Otherwise err_pulse; no write, no count change.
- S_GET_ELEM, cancel:
  - If idx>0: idx and in_count decrement, no write. The next confirm overwrites that address.
  - If idx==0: in_count<=1 -> S_GET_N.
- S_DONE:
  - input_done held at 1. Confirm is ignored, with no error.
  - Cancel: clear in_count, idx and input_done -> S_GET_M.
- Abort: enable low in any state -> S_IDLE next cycle.
  - in_count, idx and input_done are cleared.
  - dim_m/dim_n hold their last values.
  - A pending press event is discarded.
  - Debouncers keep running regardless of enable.
- Outputs: wr_addr/wr_data hold between strobes. err_pulse and wr_en are never high in the same cycle.
- Widths: sw_data is compared at the full 8 bits. For example, 8'd13 is rejected as a dimension; only accepted dimensions are truncated to 3 bits. in_count never exceeds 2+MAX_DIM^2 = 27.
- Reset mid-operation: immediate return to reset values; no partial write strobe.

Test Plan:
- Run with DEBOUNCE_CYCLES=4. btn_confirm high for 3 cycles then low -> no press event, state unchanged. Held high for 6 cycles -> exactly one event, regardless of hold length.
- enable=1; enter 2, 3, then 1,2,3,4,5,6 -> dim_m=2, dim_n=3, wr_en strobes at addr 0..5 with data 1..6, in_count ends at 8, input_done=1. A further confirm in S_DONE -> no write, no err.
- In S_GET_M enter 0, then 6, then 8'd13 -> three err_pulse, in_count=0, state stays S_GET_M. Then enter 5 -> dim_m=5.
- In S_GET_ELEM (2x2) enter 12 -> err_pulse, no wr_en. Enter 7 at idx0, then cancel, then enter 4 -> writes addr0=7 then addr0=4, in_count=3.
- Confirm and cancel events in the same cycle at idx=2 -> idx becomes 1, no write.
- Deassert enable after 3 elements -> S_IDLE, in_count=0, input_done=0, dim regs held.
- Assert rst_n low mid-debounce -> all outputs 0, no event after release.

Source files
------------

// File: rtl/matrix_input_collector.sv
// Input-mode front end: synchronises and debounces the confirm/cancel buttons,
// collects matrix dimensions m and n and then m*n element values, streaming
// each accepted element to matrix storage over a single-cycle write port.
module matrix_input_collector #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_DIM         = 5,
    parameter int MAX_VAL         = 9,
    parameter int ADDR_W          = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              btn_confirm,
    input  logic              btn_cancel,
    input  logic [7:0]        sw_data,
    output logic [7:0]        in_count,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [2:0]        dim_m,
    output logic [2:0]        dim_n,
    output logic              input_done,
    output logic              err_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_M    = 3'd1,
        S_GET_N    = 3'd2,
        S_GET_ELEM = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t            state;
    logic [1:0]        btn_raw;
    logic [1:0]        press_evt;
    logic              cfm;
    logic              cxl;
    logic              legal_dim;
    logic              legal_val;
    logic [5:0]        prod;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] target;

    // bit 0 = confirm, bit 1 = cancel
    assign btn_raw = {btn_cancel, btn_confirm};

    generate
        for (genvar b = 0; b < 2; b++) begin : g_btn
            logic             sync_p0;
            logic             sync_p1;
            logic             deb;
            logic             deb_d;
            logic             press;
            logic [CNT_W-1:0] cnt;

            // Two-flop synchroniser, stability counter and rising-edge detect of the debounced level
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_p0 <= 1'b0;
                    sync_p1 <= 1'b0;
                    deb     <= 1'b0;
                    deb_d   <= 1'b0;
                    press   <= 1'b0;
                    cnt     <= '0;
                end else begin
                    sync_p0 <= btn_raw[b];
                    sync_p1 <= sync_p0;
                    deb_d   <= deb;
                    press   <= deb & ~deb_d;
                    if (sync_p1 == deb) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        deb <= sync_p1;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign press_evt[b] = press;
        end
    endgenerate

    // Cancel takes precedence over a simultaneous confirm
    assign cxl = press_evt[1];
    assign cfm = press_evt[0] & ~press_evt[1];

    // Range checks use the full 8-bit switch value so e.g. 13 is not aliased to 5
    assign legal_dim = (sw_data >= 8'd1) && (sw_data <= 8'(MAX_DIM));
    assign legal_val = (sw_data <= 8'(MAX_VAL));
    assign prod      = {3'b000, dim_m} * {3'b000, sw_data[2:0]};

    // Entry state machine; all outputs are registered, strobes default low each cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            in_count   <= 8'd0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'd0;
            dim_m      <= 3'd0;
            dim_n      <= 3'd0;
            input_done <= 1'b0;
            err_pulse  <= 1'b0;
            idx        <= '0;
            target     <= '0;
        end else begin
            wr_en     <= 1'b0;
            err_pulse <= 1'b0;
            if (!enable) begin
                // Leaving input mode drops partial entry but keeps the last dimensions
                state      <= S_IDLE;
                in_count   <= 8'd0;
                idx        <= '0;
                input_done <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_GET_M;
                    end
                    S_GET_M: begin
                        if (cfm) begin
                            if (legal_dim) begin
                                dim_m    <= sw_data[2:0];
                                in_count <= 8'd1;
                                state    <= S_GET_N;
                            end else begin
                                err_pulse <= 1'b1;
                            end
                        end
                    end
                    S_GET_N: begin
                        if (cxl) begin
                            in_count <= 8'd0;
                            state    <= S_GET_M;
                        end else if (cfm) begin
                            if (legal_dim) begin
                                dim_n    <= sw_data[2:0];
                                in_count <= 8'd2;
                                target   <= ADDR_W'(prod);
                                idx      <= '0;
                                state    <= S_GET_ELEM;
                            end else begin
                                err_pulse <= 1'b1;
                            end
                        end
                    end
                    S_GET_ELEM: begin
                        if (cxl) begin
                            if (idx != '0) begin
                                idx      <= idx - 1'b1;
                                in_count <= in_count - 8'd1;
                            end else begin
                                in_count <= 8'd1;
                                state    <= S_GET_N;
                            end
                        end else if (cfm) begin
                            if (legal_val) begin
                                wr_en    <= 1'b1;
                                wr_addr  <= idx;
                                wr_data  <= sw_data;
                                idx      <= idx + 1'b1;
                                in_count <= in_count + 8'd1;
                                if (idx == target - 1'b1) begin
                                    state      <= S_DONE;
                                    input_done <= 1'b1;
                                end
                            end else begin
                                err_pulse <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (cxl) begin
                            in_count   <= 8'd0;
                            idx        <= '0;
                            input_done <= 1'b0;
                            state      <= S_GET_M;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_input_collector.sv
// Bench for matrix_input_collector: directed sequences plus random button
// traffic, compared against a behavioural model of the entry sequence.
module tb_matrix_input_collector;

    localparam int DB     = 4;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              btn_confirm;
    logic              btn_cancel;
    logic [7:0]        sw_data;
    logic [7:0]        in_count;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [2:0]        dim_m;
    logic [2:0]        dim_n;
    logic              input_done;
    logic              err_pulse;

    matrix_input_collector #(
        .DEBOUNCE_CYCLES(DB),
        .MAX_DIM(5),
        .MAX_VAL(9),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .btn_confirm(btn_confirm),
        .btn_cancel(btn_cancel),
        .sw_data(sw_data),
        .in_count(in_count),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .dim_m(dim_m),
        .dim_n(dim_n),
        .input_done(input_done),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    int wr_seen   = 0;
    int err_seen  = 0;
    int last_addr = 0;
    int last_data = 0;
    int overlap   = 0;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_seen++;
            last_addr = int'(wr_addr);
            last_data = int'(wr_data);
        end
        if (err_pulse === 1'b1) err_seen++;
        if (wr_en === 1'b1 && err_pulse === 1'b1) overlap = 1;
    end

    // Reference model: how many dimensions and elements have been accepted
    int m_dims  = 0;
    int m_m     = 0;
    int m_n     = 0;
    int m_elems = 0;
    int exp_wr, exp_addr, exp_data, exp_err;

    function automatic void model_event(input bit cf, input bit cx, input int v);
        exp_wr  = 0;
        exp_err = 0;
        if (!enable) return;
        if (cx) begin
            if (m_dims == 1) m_dims = 0;
            else if (m_dims == 2) begin
                if (m_elems == m_m * m_n) begin
                    m_dims  = 0;
                    m_elems = 0;
                end else if (m_elems > 0) m_elems--;
                else m_dims = 1;
            end
        end else if (cf) begin
            if (m_dims == 0) begin
                if (v >= 1 && v <= 5) begin m_m = v; m_dims = 1; end
                else exp_err = 1;
            end else if (m_dims == 1) begin
                if (v >= 1 && v <= 5) begin m_n = v; m_dims = 2; m_elems = 0; end
                else exp_err = 1;
            end else if (m_elems < m_m * m_n) begin
                if (v <= 9) begin
                    exp_wr   = 1;
                    exp_addr = m_elems;
                    exp_data = v;
                    m_elems++;
                end else exp_err = 1;
            end
        end
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".in_count"}, int'(in_count), m_dims + m_elems);
        check({tag, ".dim_m"}, int'(dim_m), m_m);
        check({tag, ".dim_n"}, int'(dim_n), m_n);
        check({tag, ".done"}, int'(input_done),
              (m_dims == 2 && m_elems == m_m * m_n) ? 1 : 0);
    endtask

    // Hold the button(s) for 'hold' cycles, release, let everything settle, then compare
    task automatic press(input string tag, input bit cf, input bit cx, input int v, input int hold);
        sw_data     = 8'(v);
        wr_seen     = 0;
        err_seen    = 0;
        btn_confirm = cf;
        btn_cancel  = cx;
        repeat (hold) @(posedge clk);
        #1;
        btn_confirm = 1'b0;
        btn_cancel  = 1'b0;
        repeat (DB + 10) @(posedge clk);
        #1;
        if (hold >= DB + 2) model_event(cf, cx, v);
        else begin exp_wr = 0; exp_err = 0; end
        check({tag, ".wr"}, wr_seen, exp_wr);
        check({tag, ".err"}, err_seen, exp_err);
        if (exp_wr == 1) begin
            check({tag, ".addr"}, last_addr, exp_addr);
            check({tag, ".data"}, last_data, exp_data);
        end
        check_state(tag);
    endtask

    task automatic set_enable(input string tag, input bit e);
        enable = e;
        repeat (3) @(posedge clk);
        #1;
        if (!e) begin
            m_dims  = 0;
            m_elems = 0;
        end
        check_state(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        btn_confirm = 1'b0;
        btn_cancel  = 1'b0;
        sw_data     = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.wr_en", int'(wr_en), 0);
        check("rst.err", int'(err_pulse), 0);
        check("rst.addr", int'(wr_addr), 0);
        check("rst.data", int'(wr_data), 0);
        check_state("rst");
        rst_n = 1'b1;

        set_enable("en_on", 1'b1);

        // Debounce: a short blip is filtered, a long hold is one event
        press("short", 1, 0, 2, 3);
        press("long", 1, 0, 2, 20);
        press("n3", 1, 0, 3, 6);
        for (int i = 1; i <= 6; i++) press("elem", 1, 0, i, 6);
        press("done_cfm", 1, 0, 7, 6);

        // Dimension range checks
        press("done_cxl", 0, 1, 0, 6);
        press("m0", 1, 0, 0, 6);
        press("m6", 1, 0, 6, 6);
        press("m13", 1, 0, 13, 6);
        press("m5", 1, 0, 5, 6);

        // 2x2 entry with value rejection, undo and overwrite
        press("n_cxl", 0, 1, 0, 6);
        press("m2", 1, 0, 2, 6);
        press("n2", 1, 0, 2, 6);
        press("v12", 1, 0, 12, 6);
        press("v7", 1, 0, 7, 6);
        press("undo", 0, 1, 0, 6);
        press("v4", 1, 0, 4, 6);
        press("v5", 1, 0, 5, 6);
        press("both", 1, 1, 6, 6);
        press("v8", 1, 0, 8, 6);
        press("v9", 1, 0, 9, 6);

        // Leave input mode with 3 elements pending
        set_enable("abort", 1'b0);
        set_enable("reenter", 1'b1);

        // Reset while the confirm button is mid-debounce
        press("m3", 1, 0, 3, 6);
        btn_confirm = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_dims = 0; m_elems = 0; m_m = 0; m_n = 0;
        check("rstmid.wr_en", int'(wr_en), 0);
        check("rstmid.err", int'(err_pulse), 0);
        check_state("rstmid");
        btn_confirm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        wr_seen = 0;
        err_seen = 0;
        repeat (DB + 10) @(posedge clk);
        #1;
        check("rstmid.no_wr", wr_seen, 0);
        check("rstmid.no_err", err_seen, 0);
        check_state("rstmid.after");

        // Random traffic
        for (int k = 0; k < 120; k++) begin
            int r, v, h;
            r = int'($urandom_range(0, 19));
            v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 10));
            h = int'($urandom_range(DB + 2, DB + 10));
            if (r == 0) set_enable("rnd_en", ~enable);
            else if (r <= 2) press("rnd_both", 1, 1, v, h);
            else if (r <= 6) press("rnd_cxl", 0, 1, v, h);
            else press("rnd_cfm", 1, 0, v, h);
        end

        check("no_wr_err_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
